// File: rtl/disp_fifo_pkg.sv
// rtl/disp_fifo_pkg.sv - shared types and timing constants for the display command FIFO ports
// No ports. Holds the writer state encoding, default strobe timing and the system clock period,
// which the reader side uses as well.
package disp_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_SETTLE = 3'd4
  } disp_state_e;

  // 120 MHz system clock
  localparam int CLK_FREQ_HZ   = 120_000_000;
  localparam int CLK_PERIOD_PS = 8333;

  // Default strobe timing, in system clock cycles
  localparam int DEF_SETUP_CYCLES  = 2;
  localparam int DEF_STROBE_CYCLES = 3;   // 25 ns low at 120 MHz
  localparam int DEF_HOLD_CYCLES   = 2;
  localparam int DEF_SETTLE_CYCLES = 3;   // covers the 2-flop full-flag sync latency
  localparam int DEF_CNT_W         = 4;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - generic two-flop synchronizer with selectable reset value
// Ports: clk, nrst (async active-low), d (asynchronous input), q (synchronized output).
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/disp_cmd_writer.sv
// rtl/disp_cmd_writer.sv - host-side writer that strobes command bytes into the display FIFO
// Ports: clk, nrst (async active-low); cmd_data/cmd_valid/cmd_ready host byte handshake;
// disp_cmd_out data bus and disp_cmd_wr active-low write strobe to the FIFO;
// nff_in active-low FIFO full flag (asynchronous); busy while a transfer is in flight;
// wr_count counts completed strobes and wraps silently.
module disp_cmd_writer
  import disp_fifo_pkg::*;
#(
  parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [7:0]  disp_cmd_out,
  output logic        disp_cmd_wr,
  input  logic        nff_in,
  output logic        busy,
  output logic [15:0] wr_count
);

  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  disp_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       out_d;
  logic             wr_d;
  logic             busy_d;
  logic             count_inc;
  logic             nff_s;
  logic             cnt_zero;
  logic             accept;

  // Reset to 0 so the FIFO reads as full until nff_in has been seen high twice.
  sync2 #(.RST_VAL(1'b0)) u_nff_sync (
    .clk  (clk),
    .nrst (nrst),
    .d    (nff_in),
    .q    (nff_s)
  );

  assign cmd_ready = (state_q == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign cnt_zero  = (cnt_q == '0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept)            state_d = ST_SETUP;
      // Full flag only gates the start of a strobe; a strobe in progress always completes.
      ST_SETUP:  if (cnt_zero && nff_s) state_d = ST_STROBE;
      ST_STROBE: if (cnt_zero)          state_d = ST_HOLD;
      ST_HOLD:   if (cnt_zero)          state_d = ST_SETTLE;
      ST_SETTLE: if (cnt_zero)          state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    out_d     = disp_cmd_out;
    wr_d      = disp_cmd_wr;
    count_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          out_d = cmd_data;
          cnt_d = SETUP_LOAD;
        end
      end
      ST_SETUP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (nff_s) begin
          wr_d  = 1'b0;
          cnt_d = STROBE_LOAD;
        end
      end
      ST_STROBE: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          wr_d      = 1'b1;
          count_inc = 1'b1;
          cnt_d     = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (!cnt_zero) cnt_d = cnt_q - CNT_W'(1);
        else           cnt_d = SETTLE_LOAD;
      end
      ST_SETTLE: begin
        if (!cnt_zero) cnt_d = cnt_q - CNT_W'(1);
      end
      default: begin
        cnt_d = '0;
        wr_d  = 1'b1;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q        <= '0;
      disp_cmd_out <= 8'h00;
      disp_cmd_wr  <= 1'b1;
      busy         <= 1'b0;
      wr_count     <= 16'h0000;
    end else begin
      cnt_q        <= cnt_d;
      disp_cmd_out <= out_d;
      disp_cmd_wr  <= wr_d;
      busy         <= busy_d;
      if (count_inc) wr_count <= wr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_disp_cmd_writer.sv
// tb/tb_disp_cmd_writer.sv - scoreboard bench for disp_cmd_writer
module tb_disp_cmd_writer;

  logic        clk = 1'b0;
  logic        nrst;
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  disp_cmd_out;
  logic        disp_cmd_wr;
  logic        nff_in;
  logic        busy;
  logic [15:0] wr_count;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] count;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] exp_count = 16'h0000;
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  time         last_acc_t;

  always #5 clk = ~clk;

  disp_cmd_writer dut (
    .clk          (clk),
    .nrst         (nrst),
    .cmd_data     (cmd_data),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .disp_cmd_out (disp_cmd_out),
    .disp_cmd_wr  (disp_cmd_wr),
    .nff_in       (nff_in),
    .busy         (busy),
    .wr_count     (wr_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every rising strobe edge is one FIFO write; pop and compare.
  initial begin : monitor
    logic       prev_wr;
    logic [7:0] prev_out;
    int         low_len;
    int         stable_len;
    exp_t       e;
    prev_wr    = 1'b1;
    prev_out   = 8'h00;
    low_len    = 0;
    stable_len = 0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        prev_wr    = 1'b1;
        low_len    = 0;
        stable_len = 0;
        prev_out   = disp_cmd_out;
        continue;
      end
      if (disp_cmd_out !== prev_out) stable_len = 1;
      else stable_len++;
      prev_out = disp_cmd_out;
      if (!disp_cmd_wr) begin
        if (prev_wr) chk("setup_ge_2", 32'(stable_len - 1 >= 2), 32'd1);
        low_len++;
      end else if (!prev_wr) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_strobe", 32'(disp_cmd_out), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk("fifo_data", 32'(disp_cmd_out), 32'(e.data));
          chk("strobe_len", 32'(low_len), 32'd3);
          chk("wr_count", 32'(wr_count), 32'(e.count));
        end
        low_len = 0;
      end
      prev_wr = disp_cmd_wr;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [7:0] b, input bit keep_valid);
    int n;
    n = 0;
    cmd_data  = b;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    last_acc_t = $time;
    exp_count  = exp_count + 16'd1;
    sb_q.push_back('{data: b, count: exp_count});
    @(negedge clk);
    if (!keep_valid) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || sb_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy || sb_q.size() != 0) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_wr_low();
    int n;
    n = 0;
    while (disp_cmd_wr && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (disp_cmd_wr) chk("strobe_timeout", 32'd0, 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    time prev_t;
    nrst      = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    nff_in    = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_wr", 32'(disp_cmd_wr), 32'd1);
    chk("rst_out", 32'(disp_cmd_out), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(wr_count), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    nrst = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte A5 with exact cycle-by-cycle timing {wr, ready, busy}
    send(8'hA5, 1'b0);
    chk("a5_bus", 32'(disp_cmd_out), 32'hA5);
    for (int k = 1; k <= 11; k++) begin
      logic exp_wr, exp_rdy;
      @(negedge clk);
      exp_wr  = !(k >= 2 && k <= 4);
      exp_rdy = (k >= 10);
      chk($sformatf("a5_timing_k%0d", k), 32'({disp_cmd_wr, cmd_ready, busy}),
          32'({exp_wr, exp_rdy, !exp_rdy}));
    end
    chk("a5_count", 32'(wr_count), 32'd1);

    // Back-to-back stream 01..10 with cmd_valid held
    prev_t = 0;
    for (int i = 1; i <= 16; i++) begin
      send(8'(i), 1'b1);
      if (i > 1) chk($sformatf("spacing_%0d", i), 32'((last_acc_t - prev_t) / 10), 32'd11);
      prev_t = last_acc_t;
    end
    cmd_valid = 1'b0;
    wait_idle();
    chk("stream_count", 32'(wr_count), 32'd17);

    // Full before accept: stall in SETUP, then release
    nff_in = 1'b0;
    repeat (3) @(negedge clk);
    send(8'h3C, 1'b0);
    repeat (10) @(negedge clk);
    chk("stall_state", 32'({disp_cmd_wr, busy, cmd_ready}), 32'b110);
    chk("stall_bus", 32'(disp_cmd_out), 32'h3C);
    nff_in = 1'b1;
    @(negedge clk);
    chk("release_r1", 32'(disp_cmd_wr), 32'd1);
    @(negedge clk);
    chk("release_r2", 32'(disp_cmd_wr), 32'd1);
    @(negedge clk);
    chk("release_r3", 32'(disp_cmd_wr), 32'd0);
    wait_idle();

    // Full asserts during strobe: strobe completes, next byte stalls
    send(8'h77, 1'b0);
    wait_wr_low();
    nff_in = 1'b0;
    send(8'h88, 1'b0);
    repeat (8) @(negedge clk);
    chk("stall2_state", 32'({disp_cmd_wr, busy}), 32'b11);
    chk("stall2_pending", 32'(sb_q.size()), 32'd1);
    nff_in = 1'b1;
    wait_idle();
    chk("stall2_count", 32'(wr_count), 32'd20);

    // Asynchronous reset mid-strobe
    send(8'h5A, 1'b0);
    wait_wr_low();
    #2;
    nrst = 1'b0;
    sb_q.delete();
    exp_count = 16'h0000;
    #1;
    chk("arst_wr", 32'(disp_cmd_wr), 32'd1);
    chk("arst_out", 32'(disp_cmd_out), 32'h00);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_count", 32'(wr_count), 32'd0);
    chk("arst_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("arst_sync_c1", 32'(dut.nff_s), 32'd0);
    @(negedge clk);
    chk("arst_sync_c2", 32'(dut.nff_s), 32'd1);
    @(negedge clk);

    // wr_count wrap
    force dut.wr_count = 16'hFFFE;
    @(negedge clk);
    release dut.wr_count;
    exp_count = 16'hFFFE;
    send(8'hC3, 1'b0);
    wait_idle();
    send(8'h3C, 1'b0);
    wait_idle();
    chk("wrap_count", 32'(wr_count), 32'h0000);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
